// File: rtl/ff_excitation_driver_if.sv
// Target-word handshake between a pattern source and ff_excitation_driver.
interface ff_excitation_driver_if #(
  parameter int WIDTH = 8
);
  logic             tgt_valid;
  logic [WIDTH-1:0] tgt_data;
  logic             tgt_ready;

  modport master (output tgt_valid, output tgt_data, input tgt_ready);
  modport slave  (input tgt_valid, input tgt_data, output tgt_ready);
endinterface

// File: rtl/ff_excitation_driver.sv
// Converts target state words into T and J/K excitation for external flip-flop banks.
// Optional read-back checker enabled by defining FF_DRV_CHECK_EN.
module ff_excitation_driver #(
  parameter int WIDTH = 8,
  parameter int CNT_W = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  ff_excitation_driver_if.slave tgt,
  output logic [WIDTH-1:0]     t_out,
  output logic [WIDTH-1:0]     j_out,
  output logic [WIDTH-1:0]     k_out,
  input  logic [WIDTH-1:0]     q_tff_in,
  input  logic [WIDTH-1:0]     q_jkff_in,
  output logic                 err,
  output logic [CNT_W-1:0]     err_count,
  output logic [WIDTH-1:0]     err_mask
);

`ifdef FF_DRV_CHECK_EN
  typedef enum logic [1:0] {IDLE, DRIVE, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, DRIVE} state_t;
`endif

  state_t           state;
  logic             ready_r;
  logic             accept;
  logic [WIDTH-1:0] tgt_p0;
  logic [WIDTH-1:0] cur_t;
  logic [WIDTH-1:0] cur_jk;

  assign tgt.tgt_ready = ready_r;
  assign accept        = (state == IDLE) && ready_r && tgt.tgt_valid;

  // Stage p0: latched target word, valid while DRIVE/CHECK are in progress
  always_ff @(posedge clk) begin
    if (accept) tgt_p0 <= tgt.tgt_data;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= IDLE;
      ready_r <= 1'b1;
      t_out   <= '0;
      j_out   <= '0;
      k_out   <= '0;
      cur_t   <= '0;
      cur_jk  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (accept) begin
            state   <= DRIVE;
            ready_r <= 1'b0;
            t_out   <= cur_t ^ tgt.tgt_data;
            j_out   <= tgt.tgt_data & ~cur_jk;
            k_out   <= ~tgt.tgt_data & cur_jk;
          end
        end
        DRIVE: begin
          t_out <= '0;
          j_out <= '0;
          k_out <= '0;
`ifdef FF_DRV_CHECK_EN
          state <= CHECK;
`else
          // Without read-back, assume the banks reached the target.
          state   <= IDLE;
          ready_r <= 1'b1;
          cur_t   <= tgt_p0;
          cur_jk  <= tgt_p0;
`endif
        end
`ifdef FF_DRV_CHECK_EN
        CHECK: begin
          // Resync to what the banks really hold so the next word corrects any miss.
          state   <= IDLE;
          ready_r <= 1'b1;
          cur_t   <= q_tff_in;
          cur_jk  <= q_jkff_in;
        end
`endif
        default: begin
          state   <= IDLE;
          ready_r <= 1'b1;
          t_out   <= '0;
          j_out   <= '0;
          k_out   <= '0;
        end
      endcase
    end
  end

`ifdef FF_DRV_CHECK_EN
  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    if (&v) return v;
    return v + 1'b1;
  endfunction

  logic [WIDTH-1:0] mism;
  assign mism = (q_tff_in ^ tgt_p0) | (q_jkff_in ^ tgt_p0);

  // Stage p1: read-back comparison at the end of CHECK
  always_ff @(posedge clk) begin
    if (reset) begin
      err       <= 1'b0;
      err_count <= '0;
      err_mask  <= '0;
    end else if (state == CHECK) begin
      err_mask <= mism;
      if (|mism) begin
        err       <= 1'b1;
        err_count <= sat_inc(err_count);
      end
    end
  end
`else
  logic unused_q;
  assign unused_q  = ^{q_tff_in, q_jkff_in};
  assign err       = 1'b0;
  assign err_count = '0;
  assign err_mask  = '0;
`endif

endmodule

// File: tb/tb_ff_excitation_driver.sv
// Directed bench for ff_excitation_driver with behavioural T and JK banks attached.
module tb_ff_excitation_driver;
  localparam int WIDTH = 8;
  localparam int CNT_W = 8;
`ifdef FF_DRV_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             reset;
  logic [WIDTH-1:0] t_out, j_out, k_out;
  logic [WIDTH-1:0] q_tff_in, q_jkff_in;
  logic             err;
  logic [CNT_W-1:0] err_count;
  logic [WIDTH-1:0] err_mask;
  logic [WIDTH-1:0] qt, qjk, stuck;
  int               tests = 0;
  int               fails = 0;

  ff_excitation_driver_if #(.WIDTH(WIDTH)) ifc ();

  ff_excitation_driver #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
    .clk       (clk),
    .reset     (reset),
    .tgt       (ifc.slave),
    .t_out     (t_out),
    .j_out     (j_out),
    .k_out     (k_out),
    .q_tff_in  (q_tff_in),
    .q_jkff_in (q_jkff_in),
    .err       (err),
    .err_count (err_count),
    .err_mask  (err_mask)
  );

  always #5 clk = ~clk;

  // T bank and JK bank, sharing the driver's reset
  always_ff @(posedge clk) begin
    if (reset) begin
      qt  <= '0;
      qjk <= '0;
    end else begin
      qt  <= qt ^ t_out;
      qjk <= (j_out & ~qjk) | (~k_out & qjk);
    end
  end

  assign q_tff_in  = qt;
  assign q_jkff_in = qjk & ~stuck;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ready(input string tag);
    int n = 0;
    while (ifc.tgt_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) chk({tag, "_ready_timeout"}, 32'(ifc.tgt_ready), 32'd1);
  endtask

  // Present one word; optionally check excitation, hold-zero and ready timing.
  task automatic push(input logic [7:0] w, input logic [7:0] et, input logic [7:0] ej,
                      input logic [7:0] ek, input string tag, input bit full);
    wait_ready(tag);
    ifc.tgt_valid = 1'b1;
    ifc.tgt_data  = w;
    @(negedge clk);
    ifc.tgt_valid = 1'b0;
    ifc.tgt_data  = ~w;
    if (full) begin
      chk({tag, "_t"}, 32'(t_out), 32'(et));
      chk({tag, "_j"}, 32'(j_out), 32'(ej));
      chk({tag, "_k"}, 32'(k_out), 32'(ek));
      chk({tag, "_rdy_lo1"}, 32'(ifc.tgt_ready), 32'd0);
    end
    @(negedge clk);
    if (full) chk({tag, "_exc_hold"}, 32'(t_out | j_out | k_out), 32'd0);
`ifdef FF_DRV_CHECK_EN
    if (full) chk({tag, "_rdy_lo2"}, 32'(ifc.tgt_ready), 32'd0);
    @(negedge clk);
`endif
    if (full) chk({tag, "_rdy_hi"}, 32'(ifc.tgt_ready), 32'd1);
  endtask

  task automatic pulse_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset         = 1'b1;
    stuck         = '0;
    ifc.tgt_valid = 1'b0;
    ifc.tgt_data  = '0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    @(negedge clk);

    chk("rst_ready", 32'(ifc.tgt_ready), 32'd1);
    chk("rst_exc", 32'(t_out | j_out | k_out), 32'd0);
    chk("rst_err", 32'({err, err_count, err_mask}), 32'd0);

    push(8'h00, 8'h00, 8'h00, 8'h00, "w00", 1'b1);
    chk("w00_err", 32'(err), 32'd0);

    push(8'hA5, 8'hA5, 8'hA5, 8'h00, "wA5", 1'b1);
    chk("wA5_qt", 32'(qt), 32'hA5);
    chk("wA5_qjk", 32'(qjk), 32'hA5);
    push(8'h5A, 8'hFF, 8'h5A, 8'hA5, "w5A", 1'b1);
    chk("w5A_qt", 32'(qt), 32'h5A);
    chk("w5A_qjk", 32'(qjk), 32'h5A);
    chk("w5A_err", 32'(err), 32'd0);

    push(8'h5A, 8'h00, 8'h00, 8'h00, "hold5A", 1'b1);
    chk("hold_qt", 32'(qt), 32'h5A);
    chk("hold_qjk", 32'(qjk), 32'h5A);
    chk("hold_err", 32'({err, err_mask}), 32'd0);

    // JK bank bit 3 reads back stuck at 0
    pulse_reset();
    stuck = 8'h08;
    push(8'h08, 8'h08, 8'h08, 8'h00, "stk1", 1'b1);
    chk("stk1_err", 32'(err), 32'(CHK));
    chk("stk1_cnt", 32'(err_count), CHK ? 32'd1 : 32'd0);
    chk("stk1_mask", 32'(err_mask), CHK ? 32'h08 : 32'h00);
    push(8'h08, 8'h00, CHK ? 8'h08 : 8'h00, 8'h00, "stk2", 1'b1);
    chk("stk2_cnt", 32'(err_count), CHK ? 32'd2 : 32'd0);

    for (int i = 0; i < 298; i++) push(8'h08, 8'h00, 8'h00, 8'h00, "sat", 1'b0);
    chk("sat_cnt", 32'(err_count), CHK ? 32'd255 : 32'd0);
    chk("sat_err", 32'(err), 32'(CHK));
    stuck = '0;

    // Reset lands while 0xFF is being driven
    wait_ready("rstdrv");
    ifc.tgt_valid = 1'b1;
    ifc.tgt_data  = 8'hFF;
    @(negedge clk);
    ifc.tgt_valid = 1'b0;
    chk("rstdrv_t", 32'(t_out), 32'(8'hFF ^ qt));
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    chk("rstdrv_exc", 32'(t_out | j_out | k_out), 32'd0);
    chk("rstdrv_ready", 32'(ifc.tgt_ready), 32'd1);
    chk("rstdrv_banks", 32'(qt | qjk), 32'd0);
    chk("rstdrv_err", 32'({err, err_count, err_mask}), 32'd0);
    push(8'h00, 8'h00, 8'h00, 8'h00, "post_rst", 1'b1);
    chk("post_rst_err", 32'(err), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end
endmodule
